picomem_bus_arbiter: RTL and testbench
======================================

// Module: picomem_bus_arbiter
// PURPOSE
//  Two-master round-robin arbiter for one PicoMem-style slave port (e.g. the GPIO or any peripheral bus).
//  Grants one master per transaction, muxes its request onto the slave and routes ready/rdata back.
//  A response watchdog completes hung transactions with an error word, so a dead slave cannot stall the CPU.
//  Sits between the core/DMA bus outputs and the shared peripheral slave.
// PARAMETERS
//  TIMEOUT_CYCLES  64           cycles in BUSY without slave ready before forced completion; 0 disables watchdog
//  ERR_RDATA       32'hDEADBEEF rdata returned to the master on a timed-out transaction
// PORTS
//  clk            in   1   system clock, all logic on rising edge
//  resetn         in   1   asynchronous active-low reset
//  m0_valid       in   1   master 0 request; held high until its ready pulse
//  m0_addr        in   32  master 0 address
//  m0_wdata       in   32  master 0 write data
//  m0_wstrb       in   4   master 0 byte strobes; 0 = read
//  m0_ready       out  1   master 0 completion pulse (1 cycle)
//  m0_rdata       out  32  master 0 read data, valid while m0_ready=1
//  m1_*           -    -   identical set for master 1 (valid/addr/wdata/wstrb in, ready/rdata out)
//  s_valid        out  1   slave request
//  s_addr         out  32  slave address
//  s_wdata        out  32  slave write data
//  s_wstrb        out  4   slave byte strobes
//  s_ready        in   1   slave completion pulse
//  s_rdata        in   32  slave read data
//  grant          out  2   one-hot owner of slave port (00 = none)
//  timeout_err    out  1   sticky: set on any watchdog completion, cleared only by reset
// BEHAVIOUR
//  - Reset (async, resetn=0): state=IDLE, grant=00, last=1 (master 0 wins first tie), counter=0, timeout_err=0.
//    All outputs read 0 immediately, including s_valid and both m*_ready. A reset mid-transaction drops it; no ready is issued.
//  - FSM states: IDLE, BUSY.
//  - IDLE: s_valid=0, s_addr/s_wdata/s_wstrb=0, m*_ready=0, m*_rdata=0.
//    - If any m*_valid is high, the winner is registered into grant and the FSM goes to BUSY next edge.
//    - Single requester wins outright.
//    - Both requesting: the master not equal to `last` wins.
//    - Arbitration costs exactly 1 cycle.
//  - BUSY: s_valid/s_addr/s_wdata/s_wstrb = granted master's signals (combinational mux on registered grant).
//    - s_ready=1: granted m*_ready=1 and m*_rdata=s_rdata in the same cycle (combinational). Next edge: last<=granted, grant<=00, IDLE.
//    - Non-granted master always sees ready=0, rdata=0.
//    - Watchdog (TIMEOUT_CYCLES>0): counter increments each BUSY cycle without s_ready.
//      - In the cycle where counter==TIMEOUT_CYCLES-1 and s_ready=0: pulse granted m*_ready with rdata=ERR_RDATA and force s_valid=0.
//      - Next edge: timeout_err<=1, last<=granted, IDLE.
//      - s_ready in that same cycle wins (normal completion, no error).
//    - Granted m*_valid drops before ready (protocol violation): s_valid follows it low. Next edge: IDLE, no ready issued, last unchanged.
//    - counter is cleared on every entry to IDLE.
//  - Throughput: at best 1 transaction per (1 + slave latency + 1) cycles. IDLE always separates transactions, so a slave that
//    registers ready never sees a stale valid.
//  - A late s_ready arriving in IDLE after a timeout is ignored; it is not forwarded to either master.
//  - The arbiter holds no data storage; address/data are never registered.
// TESTING
//  - Reset values: assert resetn=0 mid-BUSY -> same cycle s_valid=0, grant=00, m0_ready=m1_ready=0, timeout_err=0.
//  - Single master: m0 writes addr 0x0, wdata 0xA5A5A5A5, wstrb 4'hF; slave readies after 1 cycle
//    -> grant=01, s_* = m0's signals, m0_ready pulses once, m1_ready stays 0.
//  - Fairness: m0 and m1 hold valid continuously from reset
//    -> grants alternate 01,10,01,10 over 4 transactions, with 1 IDLE cycle between each.
//  - Read routing: m1 reads, slave returns s_rdata=0x12345678 -> m1_rdata=0x12345678 during m1_ready; m0_rdata=0.
//  - Watchdog: TIMEOUT_CYCLES=4, slave never readies -> on 4th BUSY cycle m0_ready=1, rdata=0xDEADBEEF, s_valid=0;
//    timeout_err=1 afterwards; a late s_ready is ignored.
//  - Race: s_ready coincides with the timeout cycle -> normal rdata returned, timeout_err stays 0.

Source files
------------

// File: rtl/picomem_bus_arbiter.sv
// rtl/picomem_bus_arbiter.sv - two-master round-robin arbiter with response watchdog
//
// Purpose: shares one PicoMem-style slave port between two masters. One master
// is granted per transaction, its request is muxed onto the slave, and the
// slave's ready/rdata are routed back to it. A watchdog completes a hung
// transaction with ERR_RDATA and sets a sticky error flag.
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   m0_valid/addr/wdata/wstrb (in)   master 0 request (wstrb==0 means read)
//   m0_ready/rdata (out)             master 0 completion pulse and read data
//   m1_*                             same set for master 1
//   s_valid/addr/wdata/wstrb (out)   slave request
//   s_ready/rdata (in)               slave completion pulse and read data
//   grant (out)                      one-hot owner of the slave port, 00 = none
//   timeout_err (out)                sticky watchdog flag, cleared only by reset
module picomem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam int unsigned CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TLAST    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = TLAST[CW-1:0];

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_q, last_d;      // index of the master served most recently
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;

  logic          sel;                 // 1 when master 1 owns the port
  logic          gnt_valid;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          wd_fire;

  assign sel       = grant_q[1];
  assign gnt_valid = sel ? m1_valid : m0_valid;
  assign wd_fire   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    terr_d    = terr_q;
    s_valid   = 1'b0;
    s_addr    = 32'h0;
    s_wdata   = 32'h0;
    s_wstrb   = 4'h0;
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_valid || m1_valid) begin
          // On a tie the master that was not served last wins.
          grant_d = (m1_valid && (!m0_valid || !last_q)) ? 2'b10 : 2'b01;
          state_d = BUSY;
        end
      end
      BUSY: begin
        s_valid = gnt_valid;
        s_addr  = sel ? m1_addr  : m0_addr;
        s_wdata = sel ? m1_wdata : m0_wdata;
        s_wstrb = sel ? m1_wstrb : m0_wstrb;
        if (!gnt_valid) begin
          // Master abandoned its request: drop it silently, fairness untouched.
          state_d = IDLE;
          grant_d = 2'b00;
          cnt_d   = '0;
        end else if (s_ready) begin
          // Slave completion takes priority over a coincident timeout.
          rsp_valid = 1'b1;
          rsp_data  = s_rdata;
          last_d    = sel;
          state_d   = IDLE;
          grant_d   = 2'b00;
          cnt_d     = '0;
        end else if (wd_fire) begin
          s_valid   = 1'b0;
          rsp_valid = 1'b1;
          rsp_data  = ERR_RDATA;
          terr_d    = 1'b1;
          last_d    = sel;
          state_d   = IDLE;
          grant_d   = 2'b00;
          cnt_d     = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  assign m0_ready    = rsp_valid && !sel;
  assign m1_ready    = rsp_valid && sel;
  assign m0_rdata    = (rsp_valid && !sel) ? rsp_data : 32'h0;
  assign m1_rdata    = (rsp_valid && sel)  ? rsp_data : 32'h0;
  assign grant       = grant_q;
  assign timeout_err = terr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

endmodule

// File: tb/tb_picomem_bus_arbiter.sv
// tb/tb_picomem_bus_arbiter.sv - self-checking bench for picomem_bus_arbiter
module tb_picomem_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid, m0_ready, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic        s_valid, s_ready, timeout_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  grant;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  picomem_bus_arbiter #(.TIMEOUT_CYCLES(4), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the request(s) already driven and the DUT in IDLE.
  // Holds s_ready low for lat BUSY cycles, then completes with rd and checks
  // the routed response against the scoreboard head.
  task automatic serve(input int lat, input logic [31:0] rd);
    exp_t e;
    logic [31:0] own_rdata, other_rdata;
    e = sb[0];
    @(negedge clk);
    chk("grant", 32'(grant), 32'(e.grant));
    chk("s_valid", 32'(s_valid), 32'd1);
    chk("s_addr", s_addr, e.addr);
    chk("s_wdata", s_wdata, e.wdata);
    chk("s_wstrb", 32'(s_wstrb), 32'(e.wstrb));
    for (int i = 0; i < lat; i++) begin
      chk("early_ready", 32'({m1_ready, m0_ready}), 32'd0);
      @(negedge clk);
    end
    s_ready = 1'b1;
    s_rdata = rd;
    #1;
    e = sb.pop_front();
    own_rdata   = e.grant[1] ? m1_rdata : m0_rdata;
    other_rdata = e.grant[1] ? m0_rdata : m1_rdata;
    chk("ready_vec", 32'({m1_ready, m0_ready}), 32'(e.grant));
    chk("rdata", own_rdata, e.rdata);
    chk("other_rdata", other_rdata, 32'd0);
    @(negedge clk);
    s_ready = 1'b0;
    s_rdata = 32'h0;
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_ready", 32'({m1_ready, m0_ready}), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    s_ready = 1'b0; s_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Single master write, slave readies after one cycle.
    m0_valid = 1'b1; m0_addr = 32'h0; m0_wdata = 32'hA5A5A5A5; m0_wstrb = 4'hF;
    sb.push_back('{2'b01, 32'h0, 32'hA5A5A5A5, 4'hF, 32'h0});
    serve(1, 32'h0);
    m0_valid = 1'b0;

    // Master 1 read routing.
    m1_valid = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    sb.push_back('{2'b10, 32'h40, 32'h0, 4'h0, 32'h12345678});
    serve(2, 32'h12345678);
    m1_valid = 1'b0;

    // Watchdog: slave never answers.
    m0_valid = 1'b1; m0_addr = 32'h80; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    @(negedge clk);
    chk("wd_grant", 32'(grant), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("wd_no_ready", 32'({m1_ready, m0_ready}), 32'd0);
      chk("wd_s_valid", 32'(s_valid), 32'd1);
      @(negedge clk);
    end
    chk("wd_ready_vec", 32'({m1_ready, m0_ready}), 32'd1);
    chk("wd_rdata", m0_rdata, 32'hDEADBEEF);
    chk("wd_s_valid_forced", 32'(s_valid), 32'd0);
    chk("wd_terr_before", 32'(timeout_err), 32'd0);
    @(negedge clk);
    chk("wd_idle_grant", 32'(grant), 32'd0);
    chk("wd_terr", 32'(timeout_err), 32'd1);
    m0_valid = 1'b0;
    s_ready = 1'b1;
    s_rdata = 32'h55555555;
    #1;
    chk("late_ready_ignored", 32'({m1_ready, m0_ready}), 32'd0);
    @(negedge clk);
    s_ready = 1'b0;
    s_rdata = 32'h0;
    chk("late_grant", 32'(grant), 32'd0);
    chk("terr_sticky", 32'(timeout_err), 32'd1);

    // Reset in the middle of a BUSY cycle with the slave answering.
    m0_valid = 1'b1; m0_addr = 32'hC0;
    @(negedge clk);
    chk("mid_grant", 32'(grant), 32'd1);
    s_ready = 1'b1;
    #1;
    resetn = 1'b0;
    #1;
    chk("mid_rst_s_valid", 32'(s_valid), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
    chk("mid_rst_terr", 32'(timeout_err), 32'd0);
    @(negedge clk);
    m0_valid = 1'b0;
    s_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // Fairness: both masters request continuously from reset.
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wdata = 32'h11; m0_wstrb = 4'h3;
    m1_valid = 1'b1; m1_addr = 32'h200; m1_wdata = 32'h22; m1_wstrb = 4'hC;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) sb.push_back('{2'b01, 32'h100, 32'h11, 4'h3, 32'h1000 + 32'(i)});
      else            sb.push_back('{2'b10, 32'h200, 32'h22, 4'hC, 32'h1000 + 32'(i)});
    end
    for (int i = 0; i < 4; i++) serve(0, 32'h1000 + 32'(i));
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    @(negedge clk);

    // Race: s_ready arrives in the timeout cycle.
    m1_valid = 1'b1; m1_addr = 32'h300; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    sb.push_back('{2'b10, 32'h300, 32'h0, 4'h0, 32'hCAFEF00D});
    serve(3, 32'hCAFEF00D);
    m1_valid = 1'b0;
    chk("race_terr", 32'(timeout_err), 32'd0);

    // Granted master drops valid before completion.
    m0_valid = 1'b1; m0_addr = 32'h400;
    @(negedge clk);
    chk("drop_grant", 32'(grant), 32'd1);
    m0_valid = 1'b0;
    #1;
    chk("drop_s_valid", 32'(s_valid), 32'd0);
    chk("drop_ready", 32'({m1_ready, m0_ready}), 32'd0);
    @(negedge clk);
    chk("drop_idle", 32'(grant), 32'd0);
    chk("drop_terr", 32'(timeout_err), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
